rv32i_hazard_ctrl: RTL and testbench
====================================

Name: rv32i_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB). It keeps a scoreboard of in-flight destination registers and holds fetch/decode on read-after-write hazards by inserting bubbles into EX. It also squashes wrong-path instructions after a taken branch resolves in EX. It does not move data: it drives the hold, issue and flush enables of the fetch/decode stages and exposes performance counters.

Parameters:
REG_AW, 5, register index width (32 architectural registers)
DEPTH, 3, scoreboard depth: cycles from ID issue until the WB write is visible to an ID read
FLUSH_CYCLES, 2, cycles of squash after a taken branch (min 1)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  core clock, all state on rising edge
RN  in  1  asynchronous active-high reset
id_valid  in  1  instruction present in IF/ID
id_rs1  in  REG_AW  source 1 index
id_rs2  in  REG_AW  source 2 index
id_uses_rs1  in  1  instruction reads rs1
id_uses_rs2  in  1  instruction reads rs2
id_rd  in  REG_AW  destination index
id_writes_rd  in  1  instruction writes rd (AR/SH/LW types)
ex_br_taken  in  1  branch in EX resolved taken this cycle
pc_hold  out  1  freeze NPC and IF/ID this cycle
id_issue  out  1  IF/ID instruction advances into EX; 0 = NOP bubble into ID/EX
if_id_flush  out  1  replace IF/ID contents with NOP at next edge
ctrl_state  out  2  0 RUN, 1 STALL, 2 FLUSH
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of taken-branch flush events

Behaviour:
- Reset (RN=1, async):
  - all scoreboard entries invalid; ctrl_state=RUN; flush counter=0; stall_cnt=flush_cnt=0.
  - Outputs while in reset: pc_hold=0, id_issue=0, if_id_flush=0.
- Scoreboard: DEPTH entries of {valid, tag}. Each edge: entry0 <= {id_issue & id_writes_rd & (id_rd!=0), id_rd}; entry[i] <= entry[i-1]; the oldest entry drops.
- pending(r) = r!=0 and any valid entry has tag==r. Register 0 never pends.
- hazard = id_valid & ((id_uses_rs1 & pending(id_rs1)) | (id_uses_rs2 & pending(id_rs2))).
- Outputs are Mealy, combinational from the current inputs plus registered state; zero latency.
- Priority, highest first:
  - Taken branch: ex_br_taken=1 or ctrl_state=FLUSH. Drive if_id_flush=1, id_issue=0, pc_hold=0. Overrides any hazard.
  - Hazard: pc_hold=1, id_issue=0, if_id_flush=0.
  - Otherwise: pc_hold=0, id_issue=id_valid, if_id_flush=0.
- FSM:
  - RUN: ex_br_taken -> FLUSH with remaining=FLUSH_CYCLES-1 (if FLUSH_CYCLES=1, stay RUN); else hazard -> STALL; else RUN.
  - STALL: ex_br_taken -> FLUSH as above; else !hazard -> RUN; else STALL.
  - FLUSH: ex_br_taken restarts remaining=FLUSH_CYCLES-1; else decrement; leave at 0 -> RUN if !hazard, STALL if hazard.
- Counters:
  - stall_cnt +1 per cycle where the hazard path drives the outputs.
  - flush_cnt +1 per cycle with ex_br_taken=1.
  - Both saturate at all-ones.
- Invariants:
  - A stall never lasts more than DEPTH consecutive cycles.
  - pc_hold and if_id_flush are never both 1.
  - id_issue=1 implies hazard=0.
- Reset mid-stall or mid-flush: state discarded immediately; the first cycle after reset is RUN with an empty scoreboard.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode constants AR_TYPE=0, M_TYPE=1, BR_TYPE=2, SH_TYPE=3;
  - funct3 codes;
  - the ctrl_state encoding;
  - the NOP instruction word.
- One natural sub-module: rv32i_scoreboard, containing the DEPTH-entry shift register and the two pending() lookups.

Test Plan:
1. Reset: assert RN mid-cycle -> outputs 0, ctrl_state=0, stall_cnt=flush_cnt=0 immediately.
2. RAW hazard: issue rd=6 (add r6,r1,r2), next ID uses rs1=6 -> pc_hold=1 for exactly 3 cycles, id_issue=1 on the 4th, stall_cnt=3.
3. x0 and no-use cases: issue rd=0 then rs1=0, and a dependent with id_uses_rs2=0 -> no stall.
4. Independent stream: 8 back-to-back instructions with disjoint regs -> id_issue=1 every cycle, stall_cnt=0.
5. Branch over hazard: ex_br_taken pulse while hazard=1 -> if_id_flush=1 for 2 cycles, pc_hold=0, flush_cnt=1. A second pulse in the FLUSH cycle extends the flush to 3 cycles and gives flush_cnt=2.
6. Reset mid-stall: RN during cycle 2 of a stall -> scoreboard empty, so the same dependent ID input issues on the first post-reset cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I core: opcode classes, funct3 codes,
// hazard-controller state encoding and the canonical NOP word.
package rv32i_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        AR_TYPE = 2'd0,
        M_TYPE  = 2'd1,
        BR_TYPE = 2'd2,
        SH_TYPE = 2'd3
    } opcode_e;

    // Arithmetic / shift funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Memory funct3
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_e;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/rv32i_scoreboard.sv
// In-flight destination tracker: a DEPTH-deep shift register of {valid, tag}
// with pending lookups for both ID source operands.
module rv32i_scoreboard
    import rv32i_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3
) (
    input  logic              clk,
    input  logic              RN,
    input  logic              push_valid,
    input  logic [REG_AW-1:0] push_tag,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              pend_rs1,
    output logic              pend_rs2
);

    logic [DEPTH-1:0]  valid;
    logic [REG_AW-1:0] tag [DEPTH];

    // NOTE: valid bits must reset so a stale entry cannot stall the first
    // instruction after reset; tags are cleared too so they never read as X.
    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample its
            // predecessor's old value, so the loop order does not matter.
            valid[0] <= push_valid;
            tag[0]   <= push_tag;
            for (int i = 1; i < DEPTH; i++) begin
                valid[i] <= valid[i-1];
                tag[i]   <= tag[i-1];
            end
        end
    end

    // NOTE: outputs get a default before the search loop so no latch is inferred.
    always_comb begin
        pend_rs1 = 1'b0;
        pend_rs2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (tag[i] == rs1)) pend_rs1 = 1'b1;
            if (valid[i] && (tag[i] == rs2)) pend_rs2 = 1'b1;
        end
        // x0 is hardwired, so it can never be waited on.
        if (rs1 == '0) pend_rs1 = 1'b0;
        if (rs2 == '0) pend_rs2 = 1'b0;
    end

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Pipeline sequencing controller: holds IF/ID on RAW hazards, squashes the
// wrong path after a taken branch and counts stall/flush events.
module rv32i_hazard_ctrl
    import rv32i_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int DEPTH        = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              RN,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_writes_rd,
    input  logic              ex_br_taken,
    output logic              pc_hold,
    output logic              id_issue,
    output logic              if_id_flush,
    output logic [1:0]        ctrl_state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int            REM_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(FLUSH_CYCLES - 1);

    ctrl_state_e      state;
    logic [REM_W-1:0] remaining;

    logic pend_rs1;
    logic pend_rs2;
    logic hazard;
    logic branch_path;
    logic stall_path;
    logic sb_push;

    assign sb_push = id_issue & id_writes_rd & (id_rd != '0);

    rv32i_scoreboard #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .RN         (RN),
        .push_valid (sb_push),
        .push_tag   (id_rd),
        .rs1        (id_rs1),
        .rs2        (id_rs2),
        .pend_rs1   (pend_rs1),
        .pend_rs2   (pend_rs2)
    );

    assign hazard      = id_valid & ((id_uses_rs1 & pend_rs1) | (id_uses_rs2 & pend_rs2));
    assign branch_path = ex_br_taken | (state == ST_FLUSH);

    // Mealy outputs; squash outranks stall so a hazard on the wrong path
    // never freezes the PC.
    always_comb begin
        pc_hold     = 1'b0;
        id_issue    = 1'b0;
        if_id_flush = 1'b0;
        stall_path  = 1'b0;
        if (!RN) begin
            if (branch_path) begin
                if_id_flush = 1'b1;
            end else if (hazard) begin
                pc_hold    = 1'b1;
                stall_path = 1'b1;
            end else begin
                id_issue = id_valid;
            end
        end
    end

    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            state     <= ST_RUN;
            remaining <= '0;
        end else begin
            case (state)
                ST_RUN, ST_STALL: begin
                    if (ex_br_taken) begin
                        if (FLUSH_CYCLES > 1) begin
                            state     <= ST_FLUSH;
                            remaining <= REM_INIT;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else begin
                        state <= hazard ? ST_STALL : ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (ex_br_taken) begin
                        remaining <= REM_INIT;
                    end else if (remaining <= REM_W'(1)) begin
                        remaining <= '0;
                        state     <= hazard ? ST_STALL : ST_RUN;
                    end else begin
                        remaining <= remaining - REM_W'(1);
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    remaining <= '0;
                end
            endcase
        end
    end

    assign ctrl_state = state;

    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_path && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (ex_br_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Scoreboard-driven bench for rv32i_hazard_ctrl: each driven cycle queues its
// expected outputs, which a negedge monitor pops and compares.
module tb_rv32i_hazard_ctrl;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic        clk = 1'b0;
    logic        rn;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  id_rd;
    logic        id_writes_rd;
    logic        ex_br_taken;
    logic        pc_hold;
    logic        id_issue;
    logic        if_id_flush;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    rv32i_hazard_ctrl #(
        .REG_AW       (5),
        .DEPTH        (3),
        .FLUSH_CYCLES (2),
        .CNT_W        (16)
    ) dut (
        .clk          (clk),
        .RN           (rn),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_rd        (id_rd),
        .id_writes_rd (id_writes_rd),
        .ex_br_taken  (ex_br_taken),
        .pc_hold      (pc_hold),
        .id_issue     (id_issue),
        .if_id_flush  (if_id_flush),
        .ctrl_state   (ctrl_state),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        hold;
        logic        issue;
        logic        flush;
        logic [1:0]  state;
        logic [15:0] stall_c;
        logic [15:0] flush_c;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   mdl_stall = 0;
    int   mdl_flush = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rn && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, ".pc_hold"},     32'(pc_hold),     32'(e.hold));
            check({e.tag, ".id_issue"},    32'(id_issue),    32'(e.issue));
            check({e.tag, ".if_id_flush"}, 32'(if_id_flush), 32'(e.flush));
            check({e.tag, ".ctrl_state"},  32'(ctrl_state),  32'(e.state));
            check({e.tag, ".stall_cnt"},   32'(stall_cnt),   32'(e.stall_c));
            check({e.tag, ".flush_cnt"},   32'(flush_cnt),   32'(e.flush_c));
            check({e.tag, ".excl"},        32'(pc_hold & if_id_flush), 32'(0));
        end
    end

    task automatic drive(input string tag, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd, input logic wr,
                         input logic br, input logic e_hold, input logic e_issue,
                         input logic e_flush, input logic [1:0] e_state);
        exp_t e;
        @(posedge clk);
        #1;
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_uses_rs1  = u1;
        id_uses_rs2  = u2;
        id_rd        = rd;
        id_writes_rd = wr;
        ex_br_taken  = br;
        e.tag     = tag;
        e.hold    = e_hold;
        e.issue   = e_issue;
        e.flush   = e_flush;
        e.state   = e_state;
        e.stall_c = 16'(mdl_stall);
        e.flush_c = 16'(mdl_flush);
        exp_q.push_back(e);
        if (e_hold) mdl_stall++;
        if (br) mdl_flush++;
    endtask

    task automatic op(input string tag, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic br, input logic e_hold, input logic e_issue, input logic e_flush,
                      input logic [1:0] e_state);
        drive(tag, 1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, br, e_hold, e_issue, e_flush, e_state);
    endtask

    task automatic idle(input string tag, input logic br, input logic e_flush, input logic [1:0] e_state);
        drive(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, br, 1'b0, 1'b0, e_flush, e_state);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".pc_hold"},     32'(pc_hold),     32'(0));
        check({tag, ".id_issue"},    32'(id_issue),    32'(0));
        check({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(0));
        check({tag, ".ctrl_state"},  32'(ctrl_state),  32'(RUN));
        check({tag, ".stall_cnt"},   32'(stall_cnt),   32'(0));
        check({tag, ".flush_cnt"},   32'(flush_cnt),   32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with a live instruction on the inputs: outputs must stay low.
        rn           = 1'b1;
        id_valid     = 1'b1;
        id_rs1       = 5'd1;
        id_rs2       = 5'd2;
        id_uses_rs1  = 1'b1;
        id_uses_rs2  = 1'b1;
        id_rd        = 5'd3;
        id_writes_rd = 1'b1;
        ex_br_taken  = 1'b1;
        #2;
        check_reset_outputs("reset");
        id_valid    = 1'b0;
        ex_br_taken = 1'b0;
        #5;
        rn = 1'b0;

        // RAW: add r6,r1,r2 then a reader of r6 stalls exactly three cycles.
        op("raw_prod", 5'd1, 5'd2, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0, RUN);
        op("raw_s1",   5'd6, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, RUN);
        op("raw_s2",   5'd6, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, STALL);
        op("raw_s3",   5'd6, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, STALL);
        op("raw_go",   5'd6, 5'd3, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, STALL);
        for (int i = 0; i < 3; i++) idle("raw_idle", 1'b0, 1'b0, RUN);

        // x0 never pends; an unused operand never stalls.
        op("x0_wr",  5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, RUN);
        op("x0_rd",  5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, RUN);
        op("nu_prod", 5'd3, 5'd4, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, RUN);
        drive("nu_rs2", 1'b1, 5'd5, 5'd9, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RUN);
        drive("nu_rs1", 1'b1, 5'd9, 5'd1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, RUN);
        for (int i = 0; i < 3; i++) idle("nu_idle", 1'b0, 1'b0, RUN);

        // Independent back-to-back stream.
        for (int i = 0; i < 8; i++) begin
            op($sformatf("ind%0d", i), 5'(20 + i), 5'(1 + i), 5'(10 + i),
               1'b0, 1'b0, 1'b1, 1'b0, RUN);
        end
        for (int i = 0; i < 3; i++) idle("ind_idle", 1'b0, 1'b0, RUN);

        // Taken branch overrides a pending hazard: two flush cycles, no hold.
        op("br_prod", 5'd1, 5'd2, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, RUN);
        op("br_hz",   5'd12, 5'd3, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, RUN);
        idle("br_f2",  1'b0, 1'b1, FLUSH);
        idle("br_end", 1'b0, 1'b0, RUN);

        // Second taken branch during the flush window extends it to three cycles.
        op("br2_prod", 5'd1, 5'd2, 5'd13, 1'b0, 1'b0, 1'b1, 1'b0, RUN);
        op("br2_hz",   5'd13, 5'd3, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, RUN);
        idle("br2_f2",  1'b1, 1'b1, FLUSH);
        idle("br2_f3",  1'b0, 1'b1, FLUSH);
        idle("br2_end", 1'b0, 1'b0, RUN);
        for (int i = 0; i < 2; i++) idle("br2_idle", 1'b0, 1'b0, RUN);

        // Reset in the second stall cycle empties the scoreboard.
        op("rs_prod", 5'd1, 5'd2, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0, RUN);
        op("rs_s1",   5'd6, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, RUN);
        @(posedge clk);
        #1;
        rn = 1'b1;
        #1;
        check_reset_outputs("rs_mid");
        mdl_stall = 0;
        mdl_flush = 0;
        #1;
        rn = 1'b0;
        op("rs_after", 5'd6, 5'd3, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, RUN);
        idle("rs_idle", 1'b0, 1'b0, RUN);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
